// File: rtl/counterup16_mod_1clk_posedge_async_resetp.sv
// 16-bit modulo up counter with clear/load, a programmable terminal value and wrap reporting.
// Optional prescaler: define COUNTERUP16_PRESCALE_EN.
module counterup16_mod_1clk_posedge_async_resetp #(
   parameter logic [15:0] RESET_VALUE = 16'h0000,
   parameter int          PRESCALE    = 4
) (
   input  logic        clock0,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic [15:0] limit,
   output logic [15:0] count,
   output logic        wrap_pulse,
   output logic [7:0]  wrap_count,
   output logic        overflow
);

   logic step;
   logic wrap;

`ifdef COUNTERUP16_PRESCALE_EN
   localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);
   logic [7:0] pscnt;

   assign step = enable && (pscnt == PS_LAST);

   always_ff @(posedge clock0 or posedge reset) begin
      if (reset)
         pscnt <= 8'd0;
      else if (clear || load)
         pscnt <= 8'd0;
      else if (enable)
         pscnt <= step ? 8'd0 : pscnt + 8'd1;
   end
`else
   // Without the prescaler every enabled edge is a step; PRESCALE is only sanity-bounded.
   assign step = enable && (PRESCALE > 0);
`endif

   // Above-limit counts also wrap, so the increment below never carries out of bit 15.
   assign wrap = step && (count >= limit);

   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         count      <= RESET_VALUE;
         wrap_pulse <= 1'b0;
         wrap_count <= 8'd0;
         overflow   <= 1'b0;
      end else if (clear) begin
         count      <= RESET_VALUE;
         wrap_pulse <= 1'b0;
         wrap_count <= 8'd0;
         overflow   <= 1'b0;
      end else if (load) begin
         count      <= load_value;
         wrap_pulse <= 1'b0;
      end else if (wrap) begin
         count      <= 16'd0;
         wrap_pulse <= 1'b1;
         if (wrap_count == 8'hFF)
            overflow   <= 1'b1;
         else
            wrap_count <= wrap_count + 8'd1;
      end else if (step) begin
         count      <= count + 16'd1;
         wrap_pulse <= 1'b0;
      end else begin
         wrap_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_counterup16_mod_1clk_posedge_async_resetp.sv
// Directed self-checking bench for counterup16_mod_1clk_posedge_async_resetp.
module tb_counterup16_mod_1clk_posedge_async_resetp;

   logic        clock0 = 1'b0;
   logic        reset, enable, clear, load;
   logic [15:0] load_value, limit;
   logic [15:0] count;
   logic        wrap_pulse;
   logic [7:0]  wrap_count;
   logic        overflow;

   int n_chk = 0;
   int n_ok  = 0;

   always #5 clock0 = ~clock0;

   counterup16_mod_1clk_posedge_async_resetp #(.RESET_VALUE(16'h0000), .PRESCALE(1)) u_dut (
      .clock0(clock0), .reset(reset), .enable(enable), .clear(clear), .load(load),
      .load_value(load_value), .limit(limit), .count(count), .wrap_pulse(wrap_pulse),
      .wrap_count(wrap_count), .overflow(overflow)
   );

`ifdef COUNTERUP16_PRESCALE_EN
   logic [15:0] p_count;
   logic        p_wrap_pulse;
   logic [7:0]  p_wrap_count;
   logic        p_overflow;

   counterup16_mod_1clk_posedge_async_resetp #(.RESET_VALUE(16'h0000), .PRESCALE(4)) u_ps (
      .clock0(clock0), .reset(reset), .enable(enable), .clear(clear), .load(load),
      .load_value(load_value), .limit(limit), .count(p_count), .wrap_pulse(p_wrap_pulse),
      .wrap_count(p_wrap_count), .overflow(p_overflow)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_ok++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock0);
      #1;
   endtask

   initial begin
      int exp_c[7] = '{1, 2, 3, 4, 5, 0, 1};
      int exp_p[7] = '{0, 0, 0, 0, 0, 1, 0};

      reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
      load_value = 16'h0; limit = 16'hFFFF;
      #2;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_pulse", 32'(wrap_pulse), 32'h0);
      chk("rst_wcnt", 32'(wrap_count), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      tick();
      reset = 1'b0;

      // asynchronous reset mid-count
      load = 1'b1; load_value = 16'h0123;
      tick();
      load = 1'b0;
      chk("load_0123", 32'(count), 32'h0123);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 32'h0);
      chk("async_rst_wcnt", 32'(wrap_count), 32'h0);
      chk("async_rst_ovf", 32'(overflow), 32'h0);
      tick();
      reset = 1'b0; enable = 1'b1;
      repeat (3) tick();
      chk("resume_3", 32'(count), 32'h3);

      // limit=5 sequence
      enable = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0; limit = 16'd5; enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("lim5_count[%0d]", i), 32'(count), 32'(exp_c[i]));
         chk($sformatf("lim5_pulse[%0d]", i), 32'(wrap_pulse), 32'(exp_p[i]));
      end
      chk("lim5_wcnt", 32'(wrap_count), 32'h1);

      // load above limit wraps on next enabled edge
      enable = 1'b0; load = 1'b1; load_value = 16'h0010;
      tick();
      load = 1'b0;
      chk("ldhi_count", 32'(count), 32'h10);
      chk("ldhi_pulse", 32'(wrap_pulse), 32'h0);
      enable = 1'b1;
      tick();
      chk("ldhi_wrap_count", 32'(count), 32'h0);
      chk("ldhi_wrap_pulse", 32'(wrap_pulse), 32'h1);
      chk("ldhi_wcnt", 32'(wrap_count), 32'h2);

      // limit=0: every enabled edge wraps; saturation then overflow
      enable = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0; limit = 16'd0; enable = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         chk($sformatf("lim0_count[%0d]", i), 32'(count), 32'h0);
         chk($sformatf("lim0_pulse[%0d]", i), 32'(wrap_pulse), 32'h1);
         if (i == 254) chk("lim0_wcnt254", 32'(wrap_count), 32'd254);
         if (i == 255) begin
            chk("lim0_wcnt255", 32'(wrap_count), 32'd255);
            chk("lim0_ovf255", 32'(overflow), 32'h0);
         end
         if (i == 256) chk("lim0_ovf256", 32'(overflow), 32'h1);
      end
      chk("lim0_wcnt_sat", 32'(wrap_count), 32'd255);
      enable = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_wcnt", 32'(wrap_count), 32'h0);
      chk("clr_ovf", 32'(overflow), 32'h0);
      chk("clr_pulse", 32'(wrap_pulse), 32'h0);

      // priority: clear > load > enable
      limit = 16'hFFFF; load = 1'b1; load_value = 16'd7;
      tick();
      chk("prio_load7", 32'(count), 32'h7);
      clear = 1'b1; enable = 1'b1;
      tick();
      clear = 1'b0;
      chk("prio_clear", 32'(count), 32'h0);
      load_value = 16'hFFFE;
      tick();
      load = 1'b0;
      chk("prio_load_fffe", 32'(count), 32'hFFFE);
      chk("prio_load_pulse", 32'(wrap_pulse), 32'h0);
      tick();
      chk("full_ffff", 32'(count), 32'hFFFF);
      chk("full_ffff_pulse", 32'(wrap_pulse), 32'h0);
      tick();
      chk("full_wrap", 32'(count), 32'h0);
      chk("full_wrap_pulse", 32'(wrap_pulse), 32'h1);
      chk("full_wcnt", 32'(wrap_count), 32'h1);
      enable = 1'b0;
      repeat (2) tick();
      chk("hold_count", 32'(count), 32'h0);
      chk("hold_pulse", 32'(wrap_pulse), 32'h0);
      chk("hold_wcnt", 32'(wrap_count), 32'h1);

      // limit decrease below count
      load = 1'b1; load_value = 16'd9;
      tick();
      load = 1'b0; limit = 16'd3; enable = 1'b1;
      tick();
      chk("limdec_count", 32'(count), 32'h0);
      chk("limdec_pulse", 32'(wrap_pulse), 32'h1);
      enable = 1'b0;

`ifdef COUNTERUP16_PRESCALE_EN
      clear = 1'b1;
      tick();
      clear = 1'b0; limit = 16'hFFFF; enable = 1'b1;
      repeat (12) tick();
      chk("ps_12", 32'(p_count), 32'h3);
      enable = 1'b0;
      repeat (5) tick();
      chk("ps_frozen", 32'(p_count), 32'h3);
      enable = 1'b1;
      repeat (3) tick();
      chk("ps_3more", 32'(p_count), 32'h3);
      tick();
      chk("ps_4more", 32'(p_count), 32'h4);
      enable = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule

// File: doc/counterup16_mod_1clk_posedge_async_resetp.md
Name: counterup16_mod_1clk_posedge_async_resetp

Overview:
16-bit modulo up counter with synchronous load and clear, a runtime-programmable terminal value, and wrap reporting. It is the count-up counterpart to the team's 16-bit down counter. It serves as the timebase/sequence generator where software sets the period through `limit` and observes wraps.
- Single clock domain (clock0).
- All outputs are registered.

Parameters:
- RESET_VALUE, 16'h0000, value loaded into count on reset, on clear, and at power-up.
- PRESCALE, 4, number of enabled cycles per count step. Only used when COUNTERUP16_PRESCALE_EN is defined; legal range 1..256.

Ports:
- clock0  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  count-advance qualifier
- clear  in  1  synchronous clear of count, wrap_count and overflow
- load  in  1  synchronous load of load_value into count
- load_value  in  16  value written on load
- limit  in  16  terminal count; count wraps to 0 after reaching it
- count  out  16  current count
- wrap_pulse  out  1  one-cycle pulse in the cycle after a wrap
- wrap_count  out  8  number of wraps since clear, saturating at 255
- overflow  out  1  sticky flag: a wrap occurred while wrap_count was 255

Behaviour:
- Reset (reset=1, asynchronous):
  - count=RESET_VALUE, wrap_pulse=0, wrap_count=0, overflow=0.
  - Outputs take these values immediately, independent of clock0.
  - Power-up initial values are identical to the reset values.
- Per rising edge, priority is clear > load > enable:
  - clear=1: count=RESET_VALUE, wrap_count=0, overflow=0, wrap_pulse=0. load and enable are ignored.
  - load=1: count=load_value, wrap_pulse=0. wrap_count and overflow hold. enable is ignored.
  - enable=1 and count < limit: count=count+1, wrap_pulse=0.
  - enable=1 and count >= limit (wrap event): count=0, wrap_pulse=1, wrap_count=min(wrap_count+1, 255). If wrap_count was already 255, overflow=1.
  - enable=0: all registers hold, wrap_pulse=0.
- Latency:
  - Every input has 1-cycle latency to the registered outputs.
  - wrap_pulse is high during the cycle in which count first shows 0 after a wrap.
- Comparison rules:
  - The comparison is unsigned 16-bit against the live limit input; limit changes take effect the next edge.
  - If count is above limit (after a load or a limit decrease), the next enabled edge wraps to 0; there is no run-on to 16'hFFFF.
  - limit=0: count stays 0 and every enabled edge is a wrap event.
  - limit=16'hFFFF: full 65536-state count; 16'hFFFF -> 0 is a wrap event.
- Arithmetic: no carry out of bit 15 is ever generated, because wrap is handled by the compare.
- overflow is cleared only by clear or reset.
- Reset asserted mid-count overrides everything. After deassertion, counting resumes from RESET_VALUE on the first enabled edge.

Optional Feature:
Macro COUNTERUP16_PRESCALE_EN.
- Defined:
  - An internal 8-bit prescale counter advances on enabled edges. The count step and wrap logic fire only when the prescaler reaches PRESCALE-1, after which the prescaler returns to 0.
  - The prescaler is zeroed by reset, clear and load.
  - enable=0 freezes the prescaler.
  - PRESCALE=1 behaves exactly like the undefined build.
- Undefined: no prescaler logic exists, and every enabled edge is a count step.

Test Plan:
- reset=1 mid-count at count=16'h0123 -> count=0, wrap_count=0, overflow=0 before the next clock edge. After release, 3 enabled cycles give count=3.
- limit=5, enable held, starting from 0 -> count sequence 1,2,3,4,5,0,1. wrap_pulse is high only in the cycle count=0, and wrap_count=1.
- load=1, load_value=16'h0010, limit=5, then enable -> count=16'h0010 after the load edge, then 0 on the next edge with wrap_pulse=1.
- limit=0, enable held for 300 cycles -> count stays 0 and wrap_pulse stays 1. wrap_count reaches 255 at cycle 255 and overflow=1 at cycle 256. A clear pulse then gives wrap_count=0 and overflow=0.
- load=1, clear=1 and enable=1 on the same edge with count=7 -> count=RESET_VALUE (clear wins). Then load=1 with enable=1 and load_value=16'hFFFE -> count=16'hFFFE, not 16'hFFFF.
- With COUNTERUP16_PRESCALE_EN defined, PRESCALE=4, limit=16'hFFFF, enable held for 12 cycles -> count=3. Dropping enable for 5 cycles leaves count and prescaler unchanged.
